// File: rtl/r_num_pkg.sv
// r_num_pkg: shared sample-path defaults, sample type and width helper
package r_num_pkg;
    localparam int WIDTH_DEF = 3;
    localparam int DEPTH_DEF = 8;
    typedef logic [WIDTH_DEF-1:0] sample_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/r_num_ring.sv
// r_num_ring: circular sample storage with wrapping write pointer and age-indexed read
module r_num_ring
    import r_num_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_raw,
    output logic [WIDTH-1:0] evict
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    ra;
    // write pointer wraps naturally because DEPTH is a power of two
    always_ff @(posedge clk)
        wp <= (rst || clr) ? '0 : en ? wp + 1'b1 : wp;
    // storage is not reset; stale entries are masked by the fill count upstream
    always_ff @(posedge clk)
        if (en && !rst && !clr) mem[wp] <= d;
    // newest entry sits one behind the write pointer
    always_comb begin
        ra     = wp - 1'b1 - rd_idx;
        rd_raw = mem[ra];
        evict  = mem[wp];
    end
endmodule

// File: rtl/r_num_hist.sv
// r_num_hist: sample history with fill count, running sum, average and change pulse
module r_num_hist
    import r_num_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW   = clog2(DEPTH),
    localparam int SW   = WIDTH + AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    input  logic [AW-1:0]    rd_idx,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic [SW-1:0]    sum,
    output logic [WIDTH-1:0] avg,
    output logic             chg
);
    logic [WIDTH-1:0] rd_raw;
    logic [WIDTH-1:0] evict;
    logic [SW-1:0]    sum_n;
    logic [AW:0]      count_inc;
    r_num_ring #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ring (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (en),
        .d      (d),
        .rd_idx (rd_idx),
        .rd_raw (rd_raw),
        .evict  (evict)
    );
    // next running sum drops the evicted oldest entry only once the history is full
    always_comb begin
        count_inc = count + 1'b1;
        sum_n     = sum + SW'(d) - (full ? SW'(evict) : SW'(0));
        rd_data   = ({1'b0, rd_idx} < count) ? rd_raw : '0;
    end
    // aggregate state; rst and clr both wipe it, en captures, otherwise hold with chg low
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q     <= '0;
            count <= '0;
            full  <= 1'b0;
            sum   <= '0;
            avg   <= '0;
            chg   <= 1'b0;
        end else if (en) begin
            q     <= d;
            count <= full ? (AW+1)'(DEPTH) : count_inc;
            full  <= full || (count_inc >= (AW+1)'(DEPTH));
            sum   <= sum_n;
            avg   <= sum_n[SW-1:AW];
            chg   <= (count != '0) && (d != q);
        end else begin
            chg   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_r_num_hist.sv
// tb_r_num_hist: directed checks of r_num_hist at WIDTH=3, DEPTH=4
module tb_r_num_hist;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] d = '0;
    logic [1:0] rd_idx = '0;
    logic [2:0] q;
    logic [2:0] rd_data;
    logic [2:0] count;
    logic       full;
    logic [4:0] sum;
    logic [2:0] avg;
    logic       chg;
    int n_vec = 0;
    int n_bad = 0;

    r_num_hist #(.WIDTH(3), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .rd_idx(rd_idx),
        .q(q), .rd_data(rd_data), .count(count), .full(full), .sum(sum),
        .avg(avg), .chg(chg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [2:0] v);
        en = 1'b1;
        d = v;
        step();
        en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [1:0] i, input logic [2:0] exp);
        rd_idx = i;
        #1;
        chk(tag, 8'(rd_data), 8'(exp));
    endtask

    task automatic agg(input string tag, input logic [2:0] eq, input logic [2:0] ec,
                       input logic ef, input logic [4:0] es, input logic [2:0] ea, input logic eg);
        chk({tag, ".q"}, 8'(q), 8'(eq));
        chk({tag, ".count"}, 8'(count), 8'(ec));
        chk({tag, ".full"}, 8'(full), 8'(ef));
        chk({tag, ".sum"}, 8'(sum), 8'(es));
        chk({tag, ".avg"}, 8'(avg), 8'(ea));
        chk({tag, ".chg"}, 8'(chg), 8'(eg));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; d = 3'd5;
        step(); step();
        rst = 1'b0; en = 1'b0;
        agg("reset", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) rd("reset.rd", 2'(i), 0);

        cap(1); cap(2); cap(3);
        agg("fill3", 3, 3, 0, 6, 1, 1);
        rd("fill3.rd0", 0, 3);
        rd("fill3.rd1", 1, 2);
        rd("fill3.rd2", 2, 1);
        rd("fill3.rd3", 3, 0);
        cap(4);
        agg("fill4", 4, 4, 1, 10, 2, 1);

        cap(7);
        agg("wrap", 7, 4, 1, 16, 4, 1);
        rd("wrap.rd0", 0, 7);
        rd("wrap.rd3", 3, 2);
        cap(7); cap(7); cap(7);
        agg("sat7", 7, 4, 1, 28, 7, 0);

        cap(5);
        chk("chg.7to5", 8'(chg), 1);
        cap(5);
        chk("chg.5to5", 8'(chg), 0);
        cap(6);
        agg("chg.5to6", 6, 4, 1, 23, 5, 1);
        step();
        chk("chg.pulse_end", 8'(chg), 0);

        for (int i = 0; i < 10; i++) begin
            d = 3'($urandom_range(0, 7));
            step();
            chk("hold.chg", 8'(chg), 0);
        end
        agg("hold", 6, 4, 1, 23, 5, 0);
        rd("hold.rd0", 0, 6);
        rd("hold.rd1", 1, 5);
        rd("hold.rd3", 3, 7);

        clr = 1'b1; en = 1'b1; d = 3'd3;
        step();
        clr = 1'b0; en = 1'b0;
        agg("clr_en", 0, 0, 0, 0, 0, 0);
        rd("clr_en.rd0", 0, 0);

        cap(2);
        agg("after_clr", 2, 1, 0, 2, 0, 0);
        rd("after_clr.rd0", 0, 2);
        rd("after_clr.rd1", 1, 0);
        cap(4);
        agg("after_clr2", 4, 2, 0, 6, 1, 1);

        en = 1'b1; d = 3'd1;
        step();
        rst = 1'b1; d = 3'd5;
        step();
        rst = 1'b0; en = 1'b0;
        agg("rst_burst", 0, 0, 0, 0, 0, 0);
        rd("rst_burst.rd0", 0, 0);
        cap(3);
        agg("after_rst", 3, 1, 0, 3, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
